// File: rtl/bp_pkg.sv
// Shared types, counter constants and PC field extraction for the BHT/BTB branch predictor.
package bp_pkg;

  localparam int unsigned BP_XLEN  = 32;
  localparam int unsigned BP_TAG_W = 8;
  localparam int unsigned BP_CTR_W = 2;

  // One table entry at the default configuration.
  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

  function automatic logic [31:0] ctr_weak_nt(input int unsigned w);
    return 32'((64'd1 << (w - 1)) - 64'd1);
  endfunction

  function automatic logic [31:0] ctr_weak_t(input int unsigned w);
    return 32'(64'd1 << (w - 1));
  endfunction

  function automatic logic [31:0] ctr_max(input int unsigned w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Word-aligned PC: index sits just above the two byte-offset bits.
  function automatic logic [31:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [31:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    logic [63:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with load; used for BHT counters and statistics.
module sat_counter #(
  parameter int unsigned W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// BHT + BTB branch predictor with combinational predict and edge-triggered training.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [XLEN-1:0]            pred_pc_i,
  output logic                       pred_taken_o,
  output logic [XLEN-1:0]            pred_target_o,
  output logic [$clog2(ENTRIES)-1:0] pred_ghr_o,
  input  logic                       upd_valid_i,
  input  logic [XLEN-1:0]            upd_pc_i,
  input  logic [$clog2(ENTRIES)-1:0] upd_ghr_i,
  input  logic                       upd_taken_i,
  input  logic [XLEN-1:0]            upd_target_i,
  input  logic                       upd_mispred_i,
  output logic [STAT_W-1:0]          stat_upd_o,
  output logic [STAT_W-1:0]          stat_mispred_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));

  // Same layout as bp_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0] ctr_w    [ENTRIES];

  logic [IDX_W-1:0] ghr_c;
  logic [IDX_W-1:0] upd_hist_c;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Non-speculative history: shifted only by resolved branches.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) ghr_d = IDX_W'({ghr_q, upd_taken_i});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign ghr_c      = ghr_q;
  assign upd_hist_c = upd_ghr_i;
`else
  logic unused_ghr;
  assign unused_ghr = ^upd_ghr_i;
  assign ghr_c      = '0;
  assign upd_hist_c = '0;
`endif

  logic [IDX_W-1:0] p_idx, u_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  entry_t           p_ent, u_ent;
  logic             p_hit, u_hit;

  assign p_idx = IDX_W'(bp_index(64'(pred_pc_i), IDX_W)) ^ ghr_c;
  assign p_tag = TAG_W'(bp_tag(64'(pred_pc_i), IDX_W, TAG_W));
  assign u_idx = IDX_W'(bp_index(64'(upd_pc_i), IDX_W)) ^ upd_hist_c;
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc_i), IDX_W, TAG_W));

  always_comb begin
    p_ent = '{valid: valid_q[p_idx], tag: tag_q[p_idx], target: target_q[p_idx], ctr: ctr_w[p_idx]};
    u_ent = '{valid: valid_q[u_idx], tag: tag_q[u_idx], target: target_q[u_idx], ctr: ctr_w[u_idx]};
  end

  assign p_hit = p_ent.valid && (p_ent.tag == p_tag);
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  // Predict reads registered state only, so same-cycle updates are not bypassed.
  assign pred_taken_o  = p_hit && p_ent.ctr[CTR_W-1];
  assign pred_target_o = pred_taken_o ? p_ent.target : '0;
  assign pred_ghr_o    = ghr_c;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
    end
    if (upd_valid_i && upd_taken_i) begin
      target_d[u_idx] = upd_target_i;
      if (!u_hit) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = upd_valid_i && (u_idx == IDX_W'(g));

    sat_counter #(.W(CTR_W), .RST_VAL(CTR_WEAK_NT)) u_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (sel && u_hit && upd_taken_i),
      .dec_i      (sel && u_hit && !upd_taken_i),
      .load_i     (sel && !u_hit && upd_taken_i),
      .load_val_i (CTR_WEAK_T),
      .cnt_o      (ctr_w[g])
    );
  end

  sat_counter #(.W(STAT_W), .RST_VAL('0)) u_stat_upd (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (upd_valid_i),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (stat_upd_o)
  );

  sat_counter #(.W(STAT_W), .RST_VAL('0)) u_stat_mispred (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (upd_valid_i && upd_mispred_i),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (stat_mispred_o)
  );

endmodule
